// File: rtl/hsv_core_commit.sv
// Commit/writeback stage: round-robin accept of four unit results, registered RF write,
// flush handshake. Optional retired-instruction counter under HSV_COMMIT_RETIRE_COUNT_EN.
module hsv_core_commit (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        flush_req,
    output logic        flush_ack,

    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_addr,
    input  logic [31:0] alu_rd_data,
    input  logic        alu_rd_we,

    input  logic        branch_valid_i,
    output logic        branch_ready_o,
    input  logic [4:0]  branch_rd_addr,
    input  logic [31:0] branch_rd_data,
    input  logic        branch_rd_we,

    input  logic        ctrl_status_valid_i,
    output logic        ctrl_status_ready_o,
    input  logic [4:0]  ctrl_status_rd_addr,
    input  logic [31:0] ctrl_status_rd_data,
    input  logic        ctrl_status_rd_we,

    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_we,

    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic [63:0] retire_count
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] DROP = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [4:0]  addr_in [4];
    logic [31:0] data_in [4];
    logic [3:0]  we_in;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        grant_vld;
    logic        accept;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        wr_en_q;

    assign valid      = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};
    assign we_in      = {mem_rd_we, ctrl_status_rd_we, branch_rd_we, alu_rd_we};
    assign addr_in[0] = alu_rd_addr;
    assign addr_in[1] = branch_rd_addr;
    assign addr_in[2] = ctrl_status_rd_addr;
    assign addr_in[3] = mem_rd_addr;
    assign data_in[0] = alu_rd_data;
    assign data_in[1] = branch_rd_data;
    assign data_in[2] = ctrl_status_rd_data;
    assign data_in[3] = mem_rd_data;

    // Scan from the highest offset down so the unit closest to the pointer wins.
    always_comb begin
        grant_idx = ptr_q;
        grant_vld = 1'b0;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (valid[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ready = 4'b0000;
        if (!rst_core) begin
            case (state_q)
                RUN: if (!flush_req && grant_vld) ready[grant_idx] = 1'b1;
                DROP, ACK: ready = 4'b1111;
                default: ready = 4'b0000;
            endcase
        end
    end

    assign alu_ready_o         = ready[0];
    assign branch_ready_o      = ready[1];
    assign ctrl_status_ready_o = ready[2];
    assign mem_ready_o         = ready[3];

    assign accept = (state_q == RUN) && !flush_req && grant_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req) state_d = DROP;
            DROP:    state_d = ACK;
            ACK:     if (!flush_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q   <= RUN;
            ptr_q     <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_en_q <= 1'b0;
            if (accept) begin
                ptr_q     <= grant_idx + 2'd1;
                wr_en_q   <= we_in[grant_idx] && (addr_in[grant_idx] != 5'd0);
                wr_addr_q <= addr_in[grant_idx];
                wr_data_q <= data_in[grant_idx];
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign flush_ack = (state_q == ACK);

`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            retire_q <= 64'd0;
        end else if (accept) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 64'd0;
`endif

endmodule
